// File: rtl/alu_nibble_sequencer.sv
// Sequencer that feeds a 4-bit combinational ALU one nibble per cycle.
// A wide operation (4*NIBBLES bits) is accepted over a start handshake, issued
// LSB nibble first with carry chained between nibbles for ADD, and the
// assembled result is offered with carry/zero flags over a result handshake.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start_valid/start_ready     operation handshake (ready only when idle)
//   op_a, op_b, op_sel, op_cin  operands, ALU select (0 AND,1 OR,2 XOR,3 ADD), carry-in
//   alu_a, alu_b, alu_select,   nibble drive to the external ALU
//   alu_carry_in
//   alu_output, alu_carry_out   ALU response for the current nibble
//   res_valid/res_ready         result handshake
//   res_data, res_carry,        assembled result, final ADD carry, zero flag
//   res_zero
module alu_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic [1:0]             op_sel,
  input  logic                   op_cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [1:0]             alu_select,
  output logic                   alu_carry_in,
  input  logic [3:0]             alu_output,
  input  logic                   alu_carry_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_data,
  output logic                   res_carry,
  output logic                   res_zero
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [1:0]  SelAdd = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [1:0]        sel_q, sel_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_zero_q, res_zero_d;

  logic [3:0]        nib_a, nib_b;
  logic [W-1:0]      merged;
  logic              is_add, last_nib;

  assign is_add   = (sel_q == SelAdd);
  assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

  // Select the current operand nibbles and splice the ALU result into place.
  always_comb begin
    nib_a  = '0;
    nib_b  = '0;
    merged = res_data_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib_a            = a_q[4*i +: 4];
        nib_b            = b_q[4*i +: 4];
        merged[4*i +: 4] = alu_output;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    carry_d     = carry_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          a_d         = op_a;
          b_d         = op_b;
          sel_d       = op_sel;
          idx_d       = '0;
          carry_d     = (op_sel == SelAdd) ? op_cin : 1'b0;
          res_data_d  = '0;
          res_carry_d = 1'b0;
          res_zero_d  = 1'b0;
          state_d     = StRun;
        end
      end
      StRun: begin
        res_data_d = merged;
        carry_d    = is_add ? alu_carry_out : 1'b0;
        if (last_nib) begin
          res_carry_d = is_add ? alu_carry_out : 1'b0;
          res_zero_d  = (merged == '0);
          state_d     = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      carry_q     <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      carry_q     <= carry_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
    end
  end

  // ALU drive is only live during RUN; zero otherwise so the ALU sees a quiet bus.
  always_comb begin
    start_ready  = (state_q == StIdle);
    res_valid    = (state_q == StDone);
    alu_a        = '0;
    alu_b        = '0;
    alu_select   = '0;
    alu_carry_in = 1'b0;
    if (state_q == StRun) begin
      alu_a        = nib_a;
      alu_b        = nib_b;
      alu_select   = sel_q;
      alu_carry_in = carry_q;
    end
  end

  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
module tb_alu_nibble_sequencer;

  localparam int unsigned NIB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_sel;
  logic        op_cin;
  logic [3:0]  alu_a, alu_b;
  logic [1:0]  alu_select;
  logic        alu_carry_in;
  logic [3:0]  alu_output;
  logic        alu_carry_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_carry;
  logic        res_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_sel       (op_sel),
    .op_cin       (op_cin),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_select   (alu_select),
    .alu_carry_in (alu_carry_in),
    .alu_output   (alu_output),
    .alu_carry_out(alu_carry_out),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_zero     (res_zero)
  );

  // Reference 4-bit ALU standing in for the existing combinational block.
  logic [4:0] sum;
  always_comb begin
    sum           = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_carry_in};
    alu_output    = '0;
    alu_carry_out = 1'b0;
    case (alu_select)
      2'd0: alu_output = alu_a & alu_b;
      2'd1: alu_output = alu_a | alu_b;
      2'd2: alu_output = alu_a ^ alu_b;
      default: begin
        alu_output    = sum[3:0];
        alu_carry_out = sum[4];
      end
    endcase
  end

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_data;
    logic        exp_carry;
    logic        exp_zero;
    logic [3:0]  exp_cins;  // bit k = alu_carry_in on nibble k
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation; hold = cycles of res_ready=0 backpressure after res_valid,
  // inject = RUN cycle at which a stray start_valid with other operands is pulsed (-1 none).
  task automatic run_op(input vec_t v, input int hold, input int inject);
    logic [15:0] a_tr, b_tr;
    logic [3:0]  c_tr;
    logic        early_valid;
    logic        sel_bad;
    @(negedge clk);
    check({v.name, " start_ready idle"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op_a = v.a; op_b = v.b; op_sel = v.sel; op_cin = v.cin;
    @(negedge clk);
    start_valid = 1'b0;
    op_a = 16'hDEAD; op_b = 16'hBEEF; op_sel = 2'd1; op_cin = 1'b1;
    a_tr = '0; b_tr = '0; c_tr = '0; early_valid = 1'b0; sel_bad = 1'b0;
    for (int k = 0; k < int'(NIB); k++) begin
      a_tr[4*k +: 4] = alu_a;
      b_tr[4*k +: 4] = alu_b;
      c_tr[k]        = alu_carry_in;
      if (res_valid || start_ready) early_valid = 1'b1;
      if (alu_select !== v.sel) sel_bad = 1'b1;
      if (k == inject) begin
        start_valid = 1'b1;
        op_a = 16'h1111; op_b = 16'h2222; op_sel = 2'd3; op_cin = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
    end
    start_valid = 1'b0;
    check({v.name, " no valid/ready during run"}, 32'(early_valid), 32'd0);
    check({v.name, " alu_select"}, 32'(sel_bad), 32'd0);
    check({v.name, " alu_a sequence"}, 32'(a_tr), 32'(v.a));
    check({v.name, " alu_b sequence"}, 32'(b_tr), 32'(v.b));
    check({v.name, " alu_carry_in sequence"}, 32'(c_tr), 32'(v.exp_cins));
    check({v.name, " res_valid at latency"}, 32'(res_valid), 32'd1);
    check({v.name, " res_data"}, 32'(res_data), 32'(v.exp_data));
    check({v.name, " res_carry"}, 32'(res_carry), 32'(v.exp_carry));
    check({v.name, " res_zero"}, 32'(res_zero), 32'(v.exp_zero));
    check({v.name, " alu_a quiet in done"}, 32'({alu_a, alu_b, alu_select, alu_carry_in}), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({v.name, " held valid"}, 32'({res_valid, start_ready}), 32'b10);
      check({v.name, " held data"}, {res_data, 14'd0, res_carry, res_zero},
            {v.exp_data, 14'd0, v.exp_carry, v.exp_zero});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({v.name, " released"}, 32'({res_valid, start_ready}), 32'b01);
    check({v.name, " data after release"}, 32'(res_data), 32'(v.exp_data));
  endtask

  initial begin
    vecs[0] = '{"add_00ff_0001", 2'd3, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0110};
    vecs[1] = '{"add_ffff_cin",  2'd3, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 4'b1111};
    vecs[2] = '{"and_f0f0_ff00", 2'd0, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 1'b0, 1'b0, 4'b0000};
    vecs[3] = '{"xor_1234_ffff", 2'd2, 16'h1234, 16'hFFFF, 1'b0, 16'hEDCB, 1'b0, 1'b0, 4'b0000};
    vecs[4] = '{"add_1234_4321", 2'd3, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
    vecs[5] = '{"or_0a0a_5050",  2'd1, 16'h0A0A, 16'h5050, 1'b1, 16'h5A5A, 1'b0, 1'b0, 4'b0000};

    reset = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; op_sel = '0; op_cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset start_ready/res_valid", 32'({start_ready, res_valid}), 32'b10);
    check("reset res", 32'({res_data, res_carry, res_zero}), 32'd0);
    check("reset alu", 32'({alu_a, alu_b, alu_select, alu_carry_in}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i], 0, -1);

    // Backpressure: result must hold for 5 cycles
    run_op(vecs[0], 5, -1);

    // Stray start during RUN cycle 2 must be ignored
    run_op(vecs[3], 0, 2);

    // Reset in RUN cycle 2 of an ADD
    @(negedge clk);
    start_valid = 1'b1;
    op_a = 16'h00FF; op_b = 16'h0001; op_sel = 2'd3; op_cin = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun reset start_ready/res_valid", 32'({start_ready, res_valid}), 32'b10);
    check("midrun reset res", 32'({res_data, res_carry, res_zero}), 32'd0);
    check("midrun reset alu", 32'({alu_a, alu_b, alu_select, alu_carry_in}), 32'd0);
    reset = 1'b0;
    run_op(vecs[5], 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
